mac_pipe_acc: RTL and testbench

//  Pipelined, multi-lane multiply-accumulate unit, successor to the single-lane combinational MAC.

---
 rtl/mac_pipe_acc.sv | 173 +++++++++++++++++
 tb/tb_mac_pipe_acc.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pipe_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mac_pipe_acc                                                    |
// | Purpose  : Pipelined multi-lane multiply-accumulate. Each accepted beat    |
// |            multiplies LANES weight/input pairs and sums them in a tree.    |
// |            The sum is added into a running accumulator, which is seeded    |
// |            from partial_sum_in on a first beat and emitted on a last beat. |
// | Pipeline : S1 products -> S2 tree sum -> accumulate/output register        |
// | Ports    : clk, rst_n (async, active low)                                  |
// |            in_valid/in_ready, weight, inp, partial_sum_in,                 |
// |            in_first, in_last, signed_mode     : input beat                 |
// |            out_valid/out_ready, partial_sum_out, overflow : result         |
// | Config   : MAC_SATURATE_EN - clamp the accumulator on overflow instead of  |
// |            wrapping modulo 2^ACCWIDTH                                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mac_pipe_acc #(
   parameter int WIDTH    = 8,
   parameter int LANES    = 4,
   parameter int ACCWIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] weight,
   input  logic [LANES*WIDTH-1:0] inp,
   input  logic [ACCWIDTH-1:0]    partial_sum_in,
   input  logic                   in_first,
   input  logic                   in_last,
   input  logic                   signed_mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACCWIDTH-1:0]    partial_sum_out,
   output logic                   overflow
);

   localparam int PW   = 2 * WIDTH;
   localparam int SUMW = PW + $clog2(LANES);
   localparam int MSB  = ACCWIDTH - 1;

   generate
      if (ACCWIDTH < SUMW) begin : g_accwidth_check
         $error("mac_pipe_acc: ACCWIDTH must be >= 2*WIDTH+clog2(LANES)");
      end
   endgenerate

   // The whole pipeline freezes only while a result sits unaccepted.
   logic en;
   assign en       = !(out_valid && !out_ready);
   assign in_ready = en;

   // Operands are extended to the product width first, so the low PW bits of
   // a plain multiply are correct for both signed and unsigned operands.
   logic [PW-1:0] prod_d [LANES];

   generate
      for (genvar k = 0; k < LANES; k++) begin : g_lane
         logic [PW-1:0] w_ext;
         logic [PW-1:0] x_ext;
         assign w_ext = {{WIDTH{signed_mode & weight[k*WIDTH+WIDTH-1]}}, weight[k*WIDTH +: WIDTH]};
         assign x_ext = {{WIDTH{signed_mode & inp[k*WIDTH+WIDTH-1]}}, inp[k*WIDTH +: WIDTH]};
         assign prod_d[k] = w_ext * x_ext;
      end
   endgenerate

   // S1 registers
   logic [PW-1:0]       s1_prod [LANES];
   logic                s1_valid, s1_first, s1_last, s1_signed;
   logic [ACCWIDTH-1:0] s1_psum;

   // S2 registers
   logic                s2_valid, s2_first, s2_last, s2_signed;
   logic [ACCWIDTH-1:0] s2_psum;
   logic [ACCWIDTH-1:0] s2_sum;

   // Accumulator state
   logic [ACCWIDTH-1:0] acc;
   logic                ovf_trk;

   logic [SUMW-1:0]     tree_sum;
   logic [ACCWIDTH-1:0] sum_ext;

   always_comb begin
      tree_sum = '0;
      for (int k = 0; k < LANES; k++) begin
         if (s1_signed) tree_sum = tree_sum + SUMW'($signed(s1_prod[k]));
         else           tree_sum = tree_sum + SUMW'(s1_prod[k]);
      end
      if (s1_signed) sum_ext = ACCWIDTH'($signed(tree_sum));
      else           sum_ext = ACCWIDTH'(tree_sum);
   end

   logic [ACCWIDTH-1:0] base;
   logic [ACCWIDTH:0]   raw;
   logic                add_ovf;
   logic [ACCWIDTH-1:0] acc_next;
   logic                trk_next;

   always_comb begin
      base = s2_first ? s2_psum : acc;
      raw  = {1'b0, base} + {1'b0, s2_sum};
      // Signed overflow: both addends share a sign that the result lost.
      if (s2_signed) add_ovf = (base[MSB] == s2_sum[MSB]) && (raw[MSB] != base[MSB]);
      else           add_ovf = raw[ACCWIDTH];
`ifdef MAC_SATURATE_EN
      if (add_ovf) begin
         if (s2_signed) acc_next = base[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
         else           acc_next = '1;
      end else begin
         acc_next = raw[MSB:0];
      end
`else
      acc_next = raw[MSB:0];
`endif
      // A first beat starts a fresh accumulation, so older overflow is dropped.
      trk_next = (s2_first ? 1'b0 : ovf_trk) | add_ovf;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LANES; k++) s1_prod[k] <= '0;
         s1_valid        <= 1'b0;
         s1_first        <= 1'b0;
         s1_last         <= 1'b0;
         s1_signed       <= 1'b0;
         s1_psum         <= '0;
         s2_valid        <= 1'b0;
         s2_first        <= 1'b0;
         s2_last         <= 1'b0;
         s2_signed       <= 1'b0;
         s2_psum         <= '0;
         s2_sum          <= '0;
         acc             <= '0;
         ovf_trk         <= 1'b0;
         out_valid       <= 1'b0;
         partial_sum_out <= '0;
         overflow        <= 1'b0;
      end else if (en) begin
         for (int k = 0; k < LANES; k++) s1_prod[k] <= prod_d[k];
         s1_valid  <= in_valid;
         s1_first  <= in_first;
         s1_last   <= in_last;
         s1_signed <= signed_mode;
         s1_psum   <= partial_sum_in;

         s2_valid  <= s1_valid;
         s2_first  <= s1_first;
         s2_last   <= s1_last;
         s2_signed <= s1_signed;
         s2_psum   <= s1_psum;
         s2_sum    <= sum_ext;

         if (s2_valid && s2_last) begin
            partial_sum_out <= acc_next;
            overflow        <= trk_next;
            out_valid       <= 1'b1;
            acc             <= '0;
            ovf_trk         <= 1'b0;
         end else begin
            // en=1 here means any pending result is being accepted now.
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            if (s2_valid) begin
               acc     <= acc_next;
               ovf_trk <= trk_next;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mac_pipe_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mac_pipe_acc                                                 |
// | Purpose  : Self-checking bench for mac_pipe_acc (32-bit and 18-bit         |
// |            accumulator instances) against an arithmetic reference model.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mac_pipe_acc;

   typedef struct {
      longint v;
      bit     o;
      longint cyc;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_valid18, out_ready;
   logic        in_first, in_last, signed_mode;
   logic [31:0] weight, inp, psum;
   logic        in_ready, out_valid, overflow;
   logic [31:0] psum_out;
   logic        in_ready18, out_valid18, overflow18;
   logic [17:0] psum_out18;

   int     checks = 0;
   int     errors = 0;
   int     rdy_mode = 0;
   longint cyc = 0;
   longint m_acc = 0;
   bit     m_trk = 1'b0;
   res_t   got_q[$], got18_q[$], exp_q[$], exp18_q[$];

   always #5 clk = ~clk;

   mac_pipe_acc #(.WIDTH(8), .LANES(4), .ACCWIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .weight(weight), .inp(inp), .partial_sum_in(psum), .in_first(in_first),
      .in_last(in_last), .signed_mode(signed_mode), .out_valid(out_valid),
      .out_ready(out_ready), .partial_sum_out(psum_out), .overflow(overflow));

   mac_pipe_acc #(.WIDTH(8), .LANES(4), .ACCWIDTH(18)) dut18 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid18), .in_ready(in_ready18),
      .weight(weight), .inp(inp), .partial_sum_in(psum[17:0]), .in_first(in_first),
      .in_last(in_last), .signed_mode(signed_mode), .out_valid(out_valid18),
      .out_ready(out_ready), .partial_sum_out(psum_out18), .overflow(overflow18));

   always @(posedge clk) cyc <= cyc + 1;

   // Consumer: 0 always ready, 1 random, 2 never ready.
   always @(negedge clk) begin
      if (rdy_mode == 0)      out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = ($urandom % 4) != 0;
      else                    out_ready = 1'b0;
   end

   // Records every result handshake (stable from here to the next rising edge).
   always @(negedge clk) begin
      res_t r;
      #2;
      if (rst_n && out_valid && out_ready) begin
         r.v = longint'(psum_out); r.o = overflow; r.cyc = cyc;
         got_q.push_back(r);
      end
      if (rst_n && out_valid18 && out_ready) begin
         r.v = longint'(psum_out18); r.o = overflow18; r.cyc = cyc;
         got18_q.push_back(r);
      end
   end

   // Reference model: plain integer arithmetic on one accepted beat.
   function automatic void model_beat(input int aw, input bit f, input bit l, input bit s,
                                      input logic [31:0] w, input logic [31:0] x,
                                      input logic [31:0] ps);
      longint md, mx, mn, base, sum, r;
      bit     ovf, trk;
      logic [7:0] a, b;
      res_t   e;
      md   = longint'(1) << aw;
      mx   = (longint'(1) << (aw - 1)) - 1;
      mn   = -(longint'(1) << (aw - 1));
      base = f ? (longint'(ps) & (md - 1)) : m_acc;
      sum  = 0;
      for (int k = 0; k < 4; k++) begin
         a = w[k*8 +: 8];
         b = x[k*8 +: 8];
         if (s) sum += longint'($signed(a)) * longint'($signed(b));
         else   sum += longint'(a) * longint'(b);
      end
      if (s && base > mx) base -= md;
      r   = base + sum;
      ovf = s ? (r > mx || r < mn) : (r >= md);
`ifdef MAC_SATURATE_EN
      if (ovf) r = s ? ((r > mx) ? mx : mn) : md - 1;
`endif
      r   = r & (md - 1);
      trk = (f ? 1'b0 : m_trk) | ovf;
      if (l) begin
         e.v = r; e.o = trk; e.cyc = 0;
         if (aw == 18) exp18_q.push_back(e);
         else          exp_q.push_back(e);
         m_acc = 0; m_trk = 1'b0;
      end else begin
         m_acc = r; m_trk = trk;
      end
   endfunction

   task automatic model_clear();
      m_acc = 0; m_trk = 1'b0;
      exp_q.delete(); got_q.delete(); exp18_q.delete(); got18_q.delete();
   endtask

   // Presents one beat and holds it until accepted; the model sees it at acceptance.
   task automatic drive(input bit sel, input bit f, input bit l, input bit s,
                        input logic [31:0] w, input logic [31:0] x, input logic [31:0] ps);
      int n;
      @(negedge clk);
      weight = w; inp = x; psum = ps; in_first = f; in_last = l; signed_mode = s;
      if (sel) in_valid18 = 1'b1; else in_valid = 1'b1;
      #1;
      n = 0;
      while (!(sel ? in_ready18 : in_ready)) begin
         @(negedge clk); #1;
         n++;
         if (n > 200) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=0 for %0d cycles, required 1", n);
            break;
         end
      end
      @(posedge clk);
      model_beat(sel ? 18 : 32, f, l, s, w, x, ps);
      #1;
      in_valid = 1'b0; in_valid18 = 1'b0;
   endtask

   task automatic drain(input bit sel);
      int n = 0;
      rdy_mode = 0;
      while ((sel ? got18_q.size() < exp18_q.size() : got_q.size() < exp_q.size()) && n < 200) begin
         @(negedge clk); n++;
      end
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
      checks++; if (psum_out !== 32'd0) begin errors++; $display("FAIL reset_psum_out: got %h required 0", psum_out); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
      checks++; if (out_valid18 !== 1'b0) begin errors++; $display("FAIL reset_out_valid18: got %b required 0", out_valid18); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_basic();
      model_clear(); rdy_mode = 0;
      drive(0, 1, 1, 0, 32'h04030201, 32'h281E140A, 32'd5);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_edge1: out_valid %b required 0", out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_edge2: out_valid %b required 0", out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_edge3: out_valid %b required 1", out_valid); end
      checks++; if (psum_out !== 32'd305) begin errors++; $display("FAIL basic_value: got %0d required 305", psum_out); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b required 0", overflow); end
      drain(0);
      checks++;
      if (got_q.size() != 1 || exp_q.size() != 1) begin
         errors++; $display("FAIL basic_count: got %0d results required 1", got_q.size());
      end else if (got_q[0].v !== exp_q[0].v) begin
         errors++; $display("FAIL basic_model: got %0d required %0d", got_q[0].v, exp_q[0].v);
      end
   endtask

   task automatic test_signed();
      model_clear();
      drive(0, 1, 0, 1, 32'hFFFFFFFF, 32'h64646464, 32'd0);
      drive(0, 0, 0, 1, 32'hFFFFFFFF, 32'h64646464, 32'd0);
      drive(0, 0, 1, 1, 32'hFFFFFFFF, 32'h64646464, 32'd0);
      drain(0);
      checks++;
      if (got_q.size() != 1) begin
         errors++; $display("FAIL signed_count: got %0d results required 1", got_q.size());
      end else begin
         checks++;
         if (got_q[0].v !== 64'h00000000FFFFFB50 || got_q[0].o !== 1'b0) begin
            errors++; $display("FAIL signed_value: got %h/%0d required fffffb50/0", got_q[0].v, got_q[0].o);
         end
      end
   endtask

   task automatic test_back_to_back();
      model_clear();
      for (int i = 0; i < 5; i++)
         drive(0, 1, 1, 1'($urandom % 2), $urandom, $urandom, $urandom);
      drain(0);
      checks++;
      if (got_q.size() != 5) begin
         errors++; $display("FAIL b2b_count: got %0d results required 5", got_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_q[i].v !== exp_q[i].v || got_q[i].o !== exp_q[i].o) begin
               errors++; $display("FAIL b2b_value[%0d]: got %h/%0d required %h/%0d", i, got_q[i].v, got_q[i].o, exp_q[i].v, exp_q[i].o);
            end
            if (i > 0) begin
               checks++;
               if (got_q[i].cyc != got_q[i-1].cyc + 1) begin
                  errors++; $display("FAIL b2b_spacing[%0d]: gap %0d cycles required 1", i, got_q[i].cyc - got_q[i-1].cyc);
               end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit saw_stall = 1'b0;
      model_clear(); rdy_mode = 0;
      fork
         for (int i = 0; i < 6; i++)
            drive(0, 1, 1, 1'($urandom % 2), $urandom, $urandom, $urandom);
         begin
            repeat (3) @(negedge clk);
            rdy_mode = 2;
            repeat (3) @(negedge clk);
            rdy_mode = 0;
         end
         repeat (20) begin
            @(negedge clk); #1;
            if (!in_ready) saw_stall = 1'b1;
         end
      join
      drain(0);
      checks++; if (saw_stall !== 1'b1) begin errors++; $display("FAIL bp_in_ready_drop: saw_stall %b required 1", saw_stall); end
      checks++;
      if (got_q.size() != 6) begin
         errors++; $display("FAIL bp_count: got %0d results required 6", got_q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_q[i].v !== exp_q[i].v || got_q[i].o !== exp_q[i].o) begin
               errors++; $display("FAIL bp_value[%0d]: got %h/%0d required %h/%0d", i, got_q[i].v, got_q[i].o, exp_q[i].v, exp_q[i].o);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] ps;
      bit f, l;
      int n;
      model_clear(); rdy_mode = 1;
      for (int i = 0; i < 150; i++) begin
         case ($urandom % 4)
            0:       ps = $urandom;
            1:       ps = 32'hFFFFFF00 | ($urandom % 256);
            2:       ps = 32'h7FFFFF00 | ($urandom % 256);
            default: ps = 32'h80000000 | ($urandom % 256);
         endcase
         f = (i == 0) || ($urandom % 4 == 0);
         l = (i == 149) || ($urandom % 3 == 0);
         if ($urandom % 4 == 0) @(posedge clk);
         drive(0, f, l, 1'($urandom % 2), $urandom, $urandom, ps);
      end
      drain(0);
      n = exp_q.size();
      checks++;
      if (got_q.size() != n) begin
         errors++; $display("FAIL rand_count: got %0d results required %0d", got_q.size(), n);
      end else begin
         for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q[i].v !== exp_q[i].v || got_q[i].o !== exp_q[i].o) begin
               errors++; $display("FAIL rand_value[%0d]: got %h/%0d required %h/%0d", i, got_q[i].v, got_q[i].o, exp_q[i].v, exp_q[i].o);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      model_clear(); rdy_mode = 2;
      drive(0, 1, 1, 0, $urandom, $urandom, $urandom);
      drive(0, 1, 0, 0, $urandom, $urandom, $urandom);
      drive(0, 0, 0, 0, $urandom, $urandom, $urandom);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending: out_valid %b required 1", out_valid); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b required 0", out_valid); end
      checks++; if (psum_out !== 32'd0) begin errors++; $display("FAIL rstmid_psum_out: got %h required 0", psum_out); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow: got %b required 0", overflow); end
      model_clear();
      @(negedge clk); rst_n = 1'b1; rdy_mode = 0;
      drive(0, 1, 0, 1, $urandom, $urandom, $urandom);
      drive(0, 0, 0, 1, $urandom, $urandom, $urandom);
      drive(0, 0, 1, 1, $urandom, $urandom, $urandom);
      drain(0);
      checks++;
      if (got_q.size() != 1) begin
         errors++; $display("FAIL rstmid_count: got %0d results required 1", got_q.size());
      end else begin
         checks++;
         if (got_q[0].v !== exp_q[0].v || got_q[0].o !== exp_q[0].o) begin
            errors++; $display("FAIL rstmid_value: got %h/%0d required %h/%0d", got_q[0].v, got_q[0].o, exp_q[0].v, exp_q[0].o);
         end
      end
   endtask

   task automatic test_overflow();
      longint want;
`ifdef MAC_SATURATE_EN
      want = 262143;
`else
      want = 10;
`endif
      model_clear(); rdy_mode = 0;
      drive(1, 1, 1, 0, 32'h01010101, 32'h05050505, 32'd262134);
      drive(1, 1, 1, 0, 32'h01010101, 32'h05050505, 32'd100);
      drive(1, 1, 1, 1, 32'h01010101, 32'h05050505, 32'd131062);
      drive(1, 1, 0, 0, 32'h01010101, 32'h05050505, 32'd262139);
      drive(1, 0, 1, 0, 32'h01010101, 32'h05050505, 32'd0);
      drain(1);
      checks++;
      if (got18_q.size() != 4) begin
         errors++; $display("FAIL ovf_count: got %0d results required 4", got18_q.size());
      end else begin
         checks++;
         if (got18_q[0].v !== want || got18_q[0].o !== 1'b1) begin
            errors++; $display("FAIL ovf_unsigned: got %0d/%0d required %0d/1", got18_q[0].v, got18_q[0].o, want);
         end
         checks++;
         if (got18_q[1].v !== 120 || got18_q[1].o !== 1'b0) begin
            errors++; $display("FAIL ovf_cleared: got %0d/%0d required 120/0", got18_q[1].v, got18_q[1].o);
         end
         for (int i = 2; i < 4; i++) begin
            checks++;
            if (got18_q[i].v !== exp18_q[i].v || got18_q[i].o !== exp18_q[i].o) begin
               errors++; $display("FAIL ovf_model[%0d]: got %0d/%0d required %0d/%0d", i, got18_q[i].v, got18_q[i].o, exp18_q[i].v, exp18_q[i].o);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_valid18 = 1'b0; out_ready = 1'b1;
      in_first = 1'b0; in_last = 1'b0; signed_mode = 1'b0;
      weight = '0; inp = '0; psum = '0;
      repeat (3) @(negedge clk);
      test_reset();
      test_basic();
      test_signed();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_mid();
      test_overflow();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
